mvm3_requant_out: RTL and testbench
===================================

Name: mvm3_requant_out

Overview:
- Downstream stage of the mvm3 matrix-vector unit. Consumes its 16-bit signed y outputs and overflow flag over the same valid/ready handshake.
- Requantizes each y to 8-bit signed (round, shift, saturate), buffers the results in a small FIFO, and tags the last element of each output vector.
- Feeds the next network layer, which expects int8 operands.

Parameters:
- IN_W, 16, width of input y values (signed).
- OUT_W, 8, width of requantized output (signed).
- SHIFT, 4, arithmetic right-shift amount; range 0..IN_W-1.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- VEC_LEN, 3, elements per output vector (m_last period).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- s_valid  input  1  upstream data valid.
- s_ready  output  1  block can accept data_in this cycle.
- data_in  input  IN_W  signed y value from mvm3.
- overflow_in  input  1  upstream overflow flag, qualified by s_valid.
- m_valid  output  1  FIFO head valid.
- m_ready  input  1  downstream accepts the head.
- data_out  output  OUT_W  signed requantized value at FIFO head.
- m_last  output  1  head is element VEC_LEN-1 of its vector.
- sat  output  1  head value was saturated or forced by overflow.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, count=0, vector index=0, m_valid=0, s_ready=0 while asserted, data_out=0, m_last=0, sat=0.
- s_ready = (count < DEPTH). It is driven from registered count only and is combinational-free with respect to m_ready. There is no pass-through when full.
- Push: s_valid & s_ready at a clock edge. The requantized word is written to the tail the same edge.
- Pop: m_valid & m_ready at a clock edge. The head advances.
- Simultaneous push and pop: count unchanged.
- Latency: a word accepted at edge N appears with m_valid=1 at the output after edge N (visible in cycle N+1).
- data_out, m_last and sat are registered FIFO contents. They must hold stable while m_valid=1 and m_ready=0.
- m_valid = (count != 0).
- data_in is ignored when s_valid=0, including X values.
- Requant, computed in IN_W+1 bits:
  - If SHIFT>0: t = (data_in + 2^(SHIFT-1)) >>> SHIFT. This is round-half-up.
  - If SHIFT=0: t = data_in.
  - If t > 2^(OUT_W-1)-1, output +max with sat=1.
  - If t < -2^(OUT_W-1), output -min with sat=1.
  - Otherwise output t with sat=0.
- Overflow rule: if overflow_in=1, the wrapped sign is inverted.
  - data_in[IN_W-1]=1 gives +max (127).
  - data_in[IN_W-1]=0 gives -min (-128).
  - sat=1 in both cases.
- Vector index:
  - Increments on each push and wraps VEC_LEN-1 to 0.
  - m_last stored with each entry = (index == VEC_LEN-1) at push time.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Reset mid-operation: all buffered words are discarded and the vector index returns to 0. No output handshake completes during reset.

Optional Feature:
- Macro RELU_EN.
- Defined: after rounding and shifting, any negative t (including the overflow-forced -128) is clamped to 0.
  - sat=1 only for positive saturation or an overflow-forced +127.
  - A clamped negative value reports sat=0.
- Undefined: full signed requant as above; no clamping.

Test Plan:
- SHIFT=4, push 14, 32, 50 with m_ready=1 -> outputs 1, 2, 3; m_last=0,0,1; sat=0.
- Push 3000, then -5000 -> 127 with sat=1, then -128 with sat=1.
  - With RELU_EN: second output is 0 with sat=0.
- Push -50 -> -3, sat=0.
  - With RELU_EN: 0.
- overflow_in=1 with data_in=0x8000 -> 127, sat=1. overflow_in=1 with data_in=0x1000 -> -128, sat=1.
- m_ready=0, push 5 words -> s_ready drops after the 4th; the 5th stays pending.
  - Release m_ready -> 5 words out in order, data_out held stable while stalled.
  - Random s_valid/m_ready over 30 words -> order preserved; m_last on every 3rd word.
- Assert reset after 2 pushes with m_ready=0 -> m_valid=0 immediately.
  - After release, push 14 -> output 1 with m_last=0 (index restarted).

Source files
------------

// File: rtl/mvm3_requant_out.sv
// Requantizes mvm3 y values to int8, buffers them in a small FIFO, and marks the last element of each vector.
// Optional macro RELU_EN clamps negative results to zero before they enter the FIFO.
module mvm3_requant_out #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 4,
    parameter int DEPTH   = 4,
    parameter int VEC_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  data_in,
    input  logic             overflow_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             m_last,
    output logic             sat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [PTR_W:0]         DEPTH_C  = (PTR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(VEC_LEN - 1);
    localparam logic signed [IN_W:0]   ROUND_C  = (IN_W+1)'((1 << SHIFT) >> 1);
    localparam logic signed [IN_W:0]   MAX_C    = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0]   MIN_C    = (IN_W+1)'(-(1 << (OUT_W - 1)));
    localparam logic [OUT_W-1:0]       OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]       OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] wideIn;
    logic signed [IN_W:0] rounded;
    logic [OUT_W-1:0]     qData;
    logic                 qSat;

    logic [OUT_W-1:0] memData [DEPTH];
    logic             memLast [DEPTH];
    logic             memSat  [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic [IDX_W-1:0] vecIdx;
    logic             push;
    logic             pop;

    // The extra bit keeps the rounding add from wrapping at the top of the input range.
    always_comb begin
        wideIn  = {data_in[IN_W-1], data_in};
        rounded = (wideIn + ROUND_C) >>> SHIFT;
        qData   = rounded[OUT_W-1:0];
        qSat    = 1'b0;
        if (overflow_in) begin
            qSat  = 1'b1;
            qData = data_in[IN_W-1] ? OUT_MAX : OUT_MIN;
        end else if (rounded > MAX_C) begin
            qSat  = 1'b1;
            qData = OUT_MAX;
        end else if (rounded < MIN_C) begin
            qSat  = 1'b1;
            qData = OUT_MIN;
        end
`ifdef RELU_EN
        if (qData[OUT_W-1]) begin
            qData = '0;
            qSat  = 1'b0;
        end
`endif
    end

    assign s_ready = reset & (count < DEPTH_C);
    assign m_valid = (count != '0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    assign data_out = memData[rdPtr];
    assign m_last   = memLast[rdPtr];
    assign sat      = memSat[rdPtr];

    // Storage is cleared on reset so the idle outputs read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                memData[i] <= '0;
                memLast[i] <= 1'b0;
                memSat[i]  <= 1'b0;
            end
        end else if (push) begin
            memData[wrPtr] <= qData;
            memLast[wrPtr] <= (vecIdx == IDX_LAST);
            memSat[wrPtr]  <= qSat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            vecIdx <= '0;
        end else begin
            if (push) begin
                wrPtr  <= wrPtr + 1'b1;
                vecIdx <= (vecIdx == IDX_LAST) ? '0 : vecIdx + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mvm3_requant_out.sv
// Scoreboard bench for mvm3_requant_out: expected words are queued on accept and compared at the FIFO head.
// Build with RELU_EN defined to check the clamping variant.
module tb_mvm3_requant_out;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT   = 4;
    localparam int DEPTH   = 4;
    localparam int VEC_LEN = 3;
`ifdef RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        int data;
        bit last;
        bit sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  data_in;
    logic             overflow_in;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] data_out;
    logic             m_last;
    logic             sat;

    exp_t q[$];
    int   idx      = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   randDone = 1'b0;

    mvm3_requant_out #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH), .VEC_LEN(VEC_LEN)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in), .overflow_in(overflow_in),
        .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out), .m_last(m_last), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Independent reference: integer round-half-up, floor shift, then clamp.
    function automatic void model(input int d, input bit ovf, output int qv, output bit s);
        int t;
        t = (d + (1 << (SHIFT - 1))) >>> SHIFT;
        s = 1'b1;
        if (ovf)           qv = (d < 0) ? 127 : -128;
        else if (t > 127)  qv = 127;
        else if (t < -128) qv = -128;
        else begin
            qv = t;
            s  = 1'b0;
        end
        if (RELU && qv < 0) begin
            qv = 0;
            s  = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input int d, input bit ovf, input int expData, input bit expSat);
        bit acc = 1'b0;
        s_valid     = 1'b1;
        data_in     = d[IN_W-1:0];
        overflow_in = ovf;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            if (acc) begin
                q.push_back('{expData, (idx == VEC_LEN - 1), expSat});
                idx = (idx + 1) % VEC_LEN;
            end
            #1;
        end
        if (!acc) checkOutput("push_timeout", 0, 1);
        s_valid     = 1'b0;
        data_in     = 'x;
        overflow_in = 1'b0;
    endtask

    task automatic waitDrain();
        int c = 0;
        while (q.size() != 0 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (q.size() != 0) checkOutput("drain_timeout", q.size(), 0);
    endtask

    // Head of the FIFO must match the oldest queued word every cycle, stalled or not.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("m_valid", int'(m_valid), int'(q.size() != 0));
            checkOutput("s_ready", int'(s_ready), int'(q.size() < DEPTH));
            if (m_valid && q.size() != 0) begin
                checkOutput("data", int'($signed(data_out)), q[0].data);
                checkOutput("m_last", int'(m_last), int'(q[0].last));
                checkOutput("sat", int'(sat), int'(q[0].sat));
                if (m_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int qv;
        bit s;
        int d;
        bit ovf;

        reset       = 1'b0;
        s_valid     = 1'b0;
        data_in     = '0;
        overflow_in = 1'b0;
        m_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_m_valid", int'(m_valid), 0);
        checkOutput("rst_s_ready", int'(s_ready), 0);
        checkOutput("rst_data", int'(data_out), 0);
        checkOutput("rst_m_last", int'(m_last), 0);
        checkOutput("rst_sat", int'(sat), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed requant values");
        applyStimulus(14, 1'b0, 1, 1'b0);
        applyStimulus(32, 1'b0, 2, 1'b0);
        applyStimulus(50, 1'b0, 3, 1'b0);
        applyStimulus(3000, 1'b0, 127, 1'b1);
        applyStimulus(-5000, 1'b0, RELU ? 0 : -128, !RELU);
        applyStimulus(-50, 1'b0, RELU ? 0 : -3, 1'b0);
        applyStimulus(-32768, 1'b1, 127, 1'b1);
        applyStimulus(32'h1000, 1'b1, RELU ? 0 : -128, !RELU);
        applyStimulus(2039, 1'b0, 127, 1'b0);
        applyStimulus(2040, 1'b0, 127, 1'b1);
        applyStimulus(-2056, 1'b0, RELU ? 0 : -128, 1'b0);
        applyStimulus(-2057, 1'b0, RELU ? 0 : -128, !RELU);
        applyStimulus(32767, 1'b0, 127, 1'b1);
        waitDrain();

        $display("[TB] stall with full FIFO");
        m_ready = 1'b0;
        fork
            begin
                applyStimulus(16, 1'b0, 1, 1'b0);
                applyStimulus(48, 1'b0, 3, 1'b0);
                applyStimulus(-16, 1'b0, RELU ? 0 : -1, 1'b0);
                applyStimulus(200, 1'b0, 13, 1'b0);
                applyStimulus(100, 1'b0, 6, 1'b0);
            end
            begin
                repeat (8) @(negedge clk);
                checkOutput("full_s_ready", int'(s_ready), 0);
                checkOutput("full_m_valid", int'(m_valid), 1);
                checkOutput("full_head", int'($signed(data_out)), 1);
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] random handshakes");
        randDone = 1'b0;
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    d   = int'($urandom_range(0, 8000)) - 4000;
                    ovf = ($urandom_range(0, 7) == 0);
                    model(d, ovf, qv, s);
                    applyStimulus(d, ovf, qv, s);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] reset mid-operation");
        m_ready = 1'b0;
        applyStimulus(14, 1'b0, 1, 1'b0);
        applyStimulus(32, 1'b0, 2, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("midrst_m_valid", int'(m_valid), 0);
        checkOutput("midrst_s_ready", int'(s_ready), 0);
        checkOutput("midrst_data", int'(data_out), 0);
        q.delete();
        idx = 0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        m_ready = 1'b1;
        applyStimulus(14, 1'b0, 1, 1'b0);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
